// File: rtl/l2_mem_req_scheduler_if.sv
// Memory-side port of the L2 request scheduler.
// The master side (the scheduler) drives the request address, direction and
// write data. The slave side (the memory) drives request ready and the
// in-order response strobe and data.
//   req_valid / req_ready  request handshake
//   req_addr               line address
//   req_rw                 1 = write-back, 0 = line fill
//   req_data               write data
//   res_valid / res_data   response, one per accepted request, in order
interface l2_mem_req_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 128
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [BLK_W-1:0]  req_data;
  logic              res_valid;
  logic [BLK_W-1:0]  res_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/l2_mem_req_scheduler.sv
// Shares the single memory port between NUM_BANKS L2 bank request ports.
// Round-robin grant into a one-entry request register, an in-order tracker
// FIFO of bank IDs for outstanding transactions, and one-hot routing of each
// memory response back to the bank that issued it.
//   clk_i, rst_ni        clock, async active-low reset
//   flush_i              hold off new grants while high
//   bank_req_*           per-bank request ports (packed, bank b at slice b)
//   bank_res_valid_o     one-hot response strobe, bank_res_data_o shared data
//   mem                  memory-side request/response interface (master)
//   outst_cnt_o          granted but not yet responded
//   flush_done_o         single pulse once a flush has fully drained
//   spurious_err_o       sticky: a response arrived with nothing outstanding
//
// Request register FSM
//   state     | meaning
//   REQ_EMPTY | no request waiting for the memory
//   REQ_FULL  | mem.req_valid high, addr/rw/data held stable until accepted
module l2_mem_req_scheduler #(
  parameter  int NUM_BANKS = 2,
  parameter  int MAX_OUTST = 4,
  parameter  int ADDR_W    = 32,
  parameter  int BLK_W     = 128,
  localparam int CNT_W     = $clog2(MAX_OUTST) + 1,
  localparam int PTR_W     = $clog2(MAX_OUTST),
  localparam int BID_W     = $clog2(NUM_BANKS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NUM_BANKS-1:0]        bank_req_valid_i,
  output logic [NUM_BANKS-1:0]        bank_req_ready_o,
  input  logic [NUM_BANKS*ADDR_W-1:0] bank_req_addr_i,
  input  logic [NUM_BANKS-1:0]        bank_req_rw_i,
  input  logic [NUM_BANKS*BLK_W-1:0]  bank_req_data_i,
  output logic [NUM_BANKS-1:0]        bank_res_valid_o,
  output logic [BLK_W-1:0]            bank_res_data_o,
  l2_mem_req_scheduler_if.master      mem,
  output logic [CNT_W-1:0]            outst_cnt_o,
  output logic                        flush_done_o,
  output logic                        spurious_err_o
);

  typedef enum logic {REQ_EMPTY = 1'b0, REQ_FULL = 1'b1} req_state_e;

  req_state_e        state_q, state_d;
  logic [BID_W-1:0]  rr_q, win, cand;
  logic              found, drain, can_grant, grant, pop;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic              req_rw_q;
  logic [BLK_W-1:0]  req_data_q;
  logic [BID_W-1:0]  trk_q [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [NUM_BANKS-1:0] res_valid_q;
  logic [BLK_W-1:0]  res_data_q;
  logic              spur_q, fd_q, fd_seen_q, fd_fire;

  // Round-robin scan starting at rr_q, wrapping modulo NUM_BANKS.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cand = BID_W'((int'(rr_q) + i) % NUM_BANKS);
      if (!found && bank_req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // The count only moves at the clock edge, so a response in this cycle
  // cannot open a grant slot combinationally.
  assign drain     = (state_q == REQ_FULL) && mem.req_ready;
  assign can_grant = !flush_i && (cnt_q < CNT_W'(MAX_OUTST)) &&
                     ((state_q == REQ_EMPTY) || drain);
  assign grant     = can_grant && found;
  assign pop       = mem.res_valid && (cnt_q != '0);

  assign bank_req_ready_o = (grant && rst_ni) ? (NUM_BANKS'(1) << win) : '0;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= REQ_EMPTY;
    else         state_q <= state_d;
  end

  // FSM: next state (a grant refills the register even while it drains)
  always_comb begin
    state_d = state_q;
    if (grant)      state_d = REQ_FULL;
    else if (drain) state_d = REQ_EMPTY;
  end

  // FSM: outputs
  always_comb begin
    mem.req_valid = (state_q == REQ_FULL);
  end

  assign mem.req_addr = req_addr_q;
  assign mem.req_rw   = req_rw_q;
  assign mem.req_data = req_data_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // One pulse per flush episode; re-arms once flush_i drops.
  assign fd_fire = flush_i && (cnt_d == '0) && !fd_seen_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      req_rw_q    <= 1'b0;
      req_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      spur_q      <= 1'b0;
      fd_q        <= 1'b0;
      fd_seen_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      res_valid_q <= pop ? (NUM_BANKS'(1) << trk_q[rd_ptr_q]) : '0;
      fd_q        <= fd_fire;
      fd_seen_q   <= flush_i && (fd_seen_q || fd_fire);
      if (mem.res_valid && (cnt_q == '0)) spur_q <= 1'b1;
      if (grant) begin
        rr_q       <= BID_W'((int'(win) + 1) % NUM_BANKS);
        req_addr_q <= bank_req_addr_i[int'(win)*ADDR_W +: ADDR_W];
        req_rw_q   <= bank_req_rw_i[win];
        req_data_q <= bank_req_data_i[int'(win)*BLK_W +: BLK_W];
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        res_data_q <= mem.res_data;
      end
    end
  end

  // Tracker storage needs no reset: entries are only read behind wr_ptr_q.
  always_ff @(posedge clk_i) begin
    if (grant) trk_q[wr_ptr_q] <= win;
  end

  assign outst_cnt_o      = cnt_q;
  assign bank_res_valid_o = res_valid_q;
  assign bank_res_data_o  = res_data_q;
  assign flush_done_o     = fd_q;
  assign spurious_err_o   = spur_q;

endmodule

// File: tb/tb_l2_mem_req_scheduler.sv
// Bench for l2_mem_req_scheduler: directed stimulus, a queue-based reference
// model compared on every falling edge, and literal spot checks.
module tb_l2_mem_req_scheduler;
  localparam int NB = 2;
  localparam int MO = 4;
  localparam int AW = 32;
  localparam int BW = 128;
  localparam int CW = $clog2(MO) + 1;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic               rst_ni;
  logic               flush_i;
  logic [NB-1:0]      bank_req_valid_i;
  logic [NB-1:0]      bank_req_ready_o;
  logic [NB*AW-1:0]   bank_req_addr_i;
  logic [NB-1:0]      bank_req_rw_i;
  logic [NB*BW-1:0]   bank_req_data_i;
  logic [NB-1:0]      bank_res_valid_o;
  logic [BW-1:0]      bank_res_data_o;
  logic [CW-1:0]      outst_cnt_o;
  logic               flush_done_o;
  logic               spurious_err_o;

  l2_mem_req_scheduler_if #(.ADDR_W(AW), .BLK_W(BW)) mem_bus ();

  l2_mem_req_scheduler #(.NUM_BANKS(NB), .MAX_OUTST(MO), .ADDR_W(AW), .BLK_W(BW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .bank_req_valid_i (bank_req_valid_i),
    .bank_req_ready_o (bank_req_ready_o),
    .bank_req_addr_i  (bank_req_addr_i),
    .bank_req_rw_i    (bank_req_rw_i),
    .bank_req_data_i  (bank_req_data_i),
    .bank_res_valid_o (bank_res_valid_o),
    .bank_res_data_o  (bank_res_data_o),
    .mem              (mem_bus),
    .outst_cnt_o      (outst_cnt_o),
    .flush_done_o     (flush_done_o),
    .spurious_err_o   (spurious_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: pending memory request, queue of outstanding bank IDs
  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [BW-1:0] data;
  } req_t;

  req_t          m_reg[$];
  int            m_trk[$];
  int            m_rr;
  logic [NB-1:0] m_res_v;
  logic [BW-1:0] m_res_d;
  logic          m_spur, m_fd, m_fd_seen;

  always @(negedge clk_i) begin
    int            win, b;
    bit            drain, possible, fd;
    logic [NB-1:0] exp_rdy;
    req_t          r;
    if (!rst_ni) begin
      m_reg.delete();
      m_trk.delete();
      m_rr = 0; m_res_v = '0; m_res_d = '0;
      m_spur = 1'b0; m_fd = 1'b0; m_fd_seen = 1'b0;
    end else begin
      win = -1;
      for (int i = 0; i < NB; i++) begin
        b = (m_rr + i) % NB;
        if (win < 0 && bank_req_valid_i[b]) win = b;
      end
      drain    = (m_reg.size() != 0) && mem_bus.req_ready;
      possible = !flush_i && (m_trk.size() < MO) && (m_reg.size() == 0 || drain);
      exp_rdy  = (possible && win >= 0) ? (NB'(1) << win) : '0;

      chk("m_bank_req_ready", BW'(bank_req_ready_o), BW'(exp_rdy));
      chk("m_mem_req_valid", BW'(mem_bus.req_valid), BW'(m_reg.size() != 0));
      if (m_reg.size() != 0) begin
        chk("m_mem_req_addr", BW'(mem_bus.req_addr), BW'(m_reg[0].addr));
        chk("m_mem_req_rw", BW'(mem_bus.req_rw), BW'(m_reg[0].rw));
        chk("m_mem_req_data", mem_bus.req_data, m_reg[0].data);
      end
      chk("m_bank_res_valid", BW'(bank_res_valid_o), BW'(m_res_v));
      chk("m_bank_res_data", bank_res_data_o, m_res_d);
      chk("m_outst_cnt", BW'(outst_cnt_o), BW'(m_trk.size()));
      chk("m_flush_done", BW'(flush_done_o), BW'(m_fd));
      chk("m_spurious_err", BW'(spurious_err_o), BW'(m_spur));

      m_res_v = '0;
      if (mem_bus.res_valid) begin
        if (m_trk.size() == 0) m_spur = 1'b1;
        else begin
          m_res_v = NB'(1) << m_trk[0];
          m_res_d = mem_bus.res_data;
          void'(m_trk.pop_front());
        end
      end
      if (drain) void'(m_reg.pop_front());
      if (exp_rdy != '0) begin
        r.addr = bank_req_addr_i[win*AW +: AW];
        r.rw   = bank_req_rw_i[win];
        r.data = bank_req_data_i[win*BW +: BW];
        m_reg.push_back(r);
        m_trk.push_back(win);
        m_rr = (win + 1) % NB;
      end
      fd        = flush_i && (m_trk.size() == 0) && !m_fd_seen;
      m_fd_seen = flush_i && (m_fd_seen || fd);
      m_fd      = fd;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_bank(input int b, input logic v, input logic [AW-1:0] a,
                          input logic rw, input logic [BW-1:0] d);
    bank_req_valid_i[b]         = v;
    bank_req_addr_i[b*AW +: AW] = a;
    bank_req_rw_i[b]            = rw;
    bank_req_data_i[b*BW +: BW] = d;
  endtask

  task automatic resp(input logic v, input logic [BW-1:0] d);
    mem_bus.res_valid = v;
    mem_bus.res_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [BW-1:0] A5 = {16{8'hA5}};

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0;
    bank_req_valid_i = '0; bank_req_addr_i = '0; bank_req_rw_i = '0; bank_req_data_i = '0;
    mem_bus.req_ready = 1'b0; mem_bus.res_valid = 1'b0; mem_bus.res_data = '0;
    tick(); tick(); #1;
    chk("L reset cnt", BW'(outst_cnt_o), 0);
    chk("L reset mem_valid", BW'(mem_bus.req_valid), 0);
    chk("L reset res_valid", BW'(bank_res_valid_o), 0);
    rst_ni = 1'b1;

    // T1 / T3: both banks hammer, memory always ready, no responses
    tick();
    set_bank(0, 1'b1, 32'h0000_1000, 1'b0, 128'h1111);
    set_bank(1, 1'b1, 32'h0000_2000, 1'b1, 128'h2222);
    mem_bus.req_ready = 1'b1;
    #1 chk("L t1 ready k", BW'(bank_req_ready_o), BW'(2'b01));
    tick(); #1;
    chk("L t1 ready k1", BW'(bank_req_ready_o), BW'(2'b10));
    chk("L t1 addr k1", BW'(mem_bus.req_addr), BW'(32'h1000));
    tick(); #1;
    chk("L t1 ready k2", BW'(bank_req_ready_o), BW'(2'b01));
    chk("L t1 addr k2", BW'(mem_bus.req_addr), BW'(32'h2000));
    chk("L t1 rw k2", BW'(mem_bus.req_rw), 1);
    tick(); #1;
    chk("L t1 ready k3", BW'(bank_req_ready_o), BW'(2'b10));
    tick(); #1;
    chk("L t3 ready full", BW'(bank_req_ready_o), 0);
    chk("L t3 cnt full", BW'(outst_cnt_o), 4);
    tick(); resp(1'b1, 128'hD0); #1;
    chk("L t3 no grant on resp", BW'(bank_req_ready_o), 0);
    chk("L t3 drained", BW'(mem_bus.req_valid), 0);
    tick(); resp(1'b0, '0); #1;
    chk("L t3 cnt 3", BW'(outst_cnt_o), 3);
    chk("L t3 regrant", BW'(bank_req_ready_o), BW'(2'b01));
    chk("L t3 res to bank0", BW'(bank_res_valid_o), BW'(2'b01));
    chk("L t3 res data", bank_res_data_o, 128'hD0);
    tick(); bank_req_valid_i = '0; resp(1'b1, 128'hD1);
    tick(); resp(1'b1, 128'hD2); #1;
    chk("L res to bank1", BW'(bank_res_valid_o), BW'(2'b10));

    // T4: grant and response together at count 2
    tick(); bank_req_valid_i = 2'b10; resp(1'b1, 128'hD3); #1;
    chk("L t4 cnt 2", BW'(outst_cnt_o), 2);
    chk("L t4 ready", BW'(bank_req_ready_o), BW'(2'b10));
    tick(); bank_req_valid_i = '0; resp(1'b0, '0); #1;
    chk("L t4 cnt stays", BW'(outst_cnt_o), 2);
    chk("L t4 oldest bank", BW'(bank_res_valid_o), BW'(2'b10));
    tick(); resp(1'b1, 128'hD4);
    tick(); resp(1'b1, 128'hD5);
    tick(); resp(1'b0, '0); #1;
    chk("L t4 drained cnt", BW'(outst_cnt_o), 0);

    // T2: bank1 alone, response three cycles after the request
    tick(); set_bank(1, 1'b1, 32'h40, 1'b0, 128'h0); #1;
    chk("L t2 ready", BW'(bank_req_ready_o), BW'(2'b10));
    tick(); bank_req_valid_i = '0; #1;
    chk("L t2 mem valid", BW'(mem_bus.req_valid), 1);
    chk("L t2 mem addr", BW'(mem_bus.req_addr), BW'(32'h40));
    tick();
    tick(); resp(1'b1, A5);
    tick(); resp(1'b0, '0); #1;
    chk("L t2 res valid", BW'(bank_res_valid_o), BW'(2'b10));
    chk("L t2 res data", bank_res_data_o, A5);
    tick(); #1;
    chk("L t2 res one cycle", BW'(bank_res_valid_o), 0);

    // T5: memory stall, then flush with three in flight
    tick(); set_bank(0, 1'b1, 32'h3000, 1'b1, 128'h3333); mem_bus.req_ready = 1'b0; #1;
    chk("L t5 ready s", BW'(bank_req_ready_o), BW'(2'b01));
    tick(); #1;
    chk("L t5 stall blocks", BW'(bank_req_ready_o), 0);
    mem_bus.req_ready = 1'b1; #1;
    chk("L t5 drain regrant", BW'(bank_req_ready_o), BW'(2'b01));
    tick();
    tick(); flush_i = 1'b1; #1;
    chk("L t5 flush blocks", BW'(bank_req_ready_o), 0);
    chk("L t5 cnt 3", BW'(outst_cnt_o), 3);
    tick(); bank_req_valid_i = '0; resp(1'b1, 128'hE0);
    tick(); resp(1'b1, 128'hE1);
    tick(); resp(1'b1, 128'hE2); #1;
    chk("L t5 no done yet", BW'(flush_done_o), 0);
    tick(); resp(1'b0, '0); #1;
    chk("L t5 done", BW'(flush_done_o), 1);
    chk("L t5 cnt 0", BW'(outst_cnt_o), 0);
    tick(); #1;
    chk("L t5 done once", BW'(flush_done_o), 0);
    tick(); flush_i = 1'b0;
    tick(); flush_i = 1'b1; #1;
    chk("L t5 idle flush not yet", BW'(flush_done_o), 0);
    tick(); #1;
    chk("L t5 idle flush done", BW'(flush_done_o), 1);
    tick(); flush_i = 1'b0;

    // T6: spurious response, then reset in the middle of traffic
    tick(); resp(1'b1, 128'hBAD);
    tick(); resp(1'b0, '0); #1;
    chk("L t6 spurious", BW'(spurious_err_o), 1);
    chk("L t6 no strobe", BW'(bank_res_valid_o), 0);
    tick(); bank_req_valid_i = 2'b11;
    tick();
    tick(); rst_ni = 1'b0; #1;
    chk("L t6 rst ready", BW'(bank_req_ready_o), 0);
    chk("L t6 rst mem valid", BW'(mem_bus.req_valid), 0);
    chk("L t6 rst cnt", BW'(outst_cnt_o), 0);
    chk("L t6 rst spurious", BW'(spurious_err_o), 0);
    bank_req_valid_i = '0;
    tick(); rst_ni = 1'b1;
    tick(); #1;
    chk("L t6 cnt after rst", BW'(outst_cnt_o), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
